// File: rtl/jne_predictor.sv
// JNE branch predictor: 2-bit saturating counter table trained by jne_checker verdicts.
// Optional BPRED_STATS_EN adds saturating hit/miss counters (stat_hits, stat_misses).
module jne_predictor #(
  parameter int IDX_BITS = 4,
  parameter int PC_W     = 12,
  parameter int TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_req,
  input  logic [1:0]      br_type,
  input  logic [PC_W-1:0] pc,
  input  logic            checked,
  input  logic            incorrect_pred,
  input  logic            correct_pred,
  output logic            pred_taken,
  output logic            aux_last_pred,
  output logic [1:0]      aux_pred_type,
  output logic            stall,
  output logic            mispredict_flush,
  output logic            timeout_err
`ifdef BPRED_STATS_EN
  ,
  output logic [15:0]     stat_hits,
  output logic [15:0]     stat_misses
`endif
);

  localparam int         ENTRIES = 1 << IDX_BITS;
  localparam logic [7:0] TO_LIM  = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPDATE} state_t;

  state_t                    state_q;
  logic [ENTRIES-1:0][1:0]   tbl_q;
  logic [IDX_BITS-1:0]       idx_q;
  logic                      actual_q;
  logic [7:0]                tcnt_q;
  logic                      pred_q, aux_pred_q, stall_q, flush_q, tout_q;
  logic [1:0]                aux_type_q;

  logic [IDX_BITS-1:0]       rd_idx;
  logic [1:0]                rd_ctr, old_ctr, new_ctr;
  logic [7:0]                tcnt_d;
  logic                      unused_pc;

  assign rd_idx    = pc[IDX_BITS-1:0];
  assign rd_ctr    = tbl_q[rd_idx];
  assign old_ctr   = tbl_q[idx_q];
  assign tcnt_d    = tcnt_q + 8'd1;
  assign unused_pc = ^pc[PC_W-1:IDX_BITS];

  always_comb begin
    new_ctr = old_ctr;
    if (actual_q && old_ctr != 2'b11)       new_ctr = old_ctr + 2'b01;
    else if (!actual_q && old_ctr != 2'b00) new_ctr = old_ctr - 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= 2'b01;
      idx_q      <= '0;
      actual_q   <= 1'b0;
      tcnt_q     <= '0;
      pred_q     <= 1'b0;
      aux_pred_q <= 1'b0;
      aux_type_q <= 2'b00;
      stall_q    <= 1'b0;
      flush_q    <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      // pulse outputs default low; each state raises them for one cycle
      pred_q  <= 1'b0;
      flush_q <= 1'b0;
      tout_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (br_req && br_type == 2'b10) begin
            pred_q     <= rd_ctr[1];
            aux_pred_q <= rd_ctr[1];
            aux_type_q <= 2'b10;
            idx_q      <= rd_idx;
            tcnt_q     <= '0;
            stall_q    <= 1'b1;
            state_q    <= S_WAIT;
          end else if (br_req && br_type[0]) begin
            pred_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (checked) begin
            actual_q <= correct_pred;
            flush_q  <= incorrect_pred;
            state_q  <= S_UPDATE;
          end else begin
            tcnt_q <= tcnt_d;
            if (tcnt_d == TO_LIM) begin
              tout_q  <= 1'b1;
              stall_q <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        S_UPDATE: begin
          tbl_q[idx_q] <= new_ctr;
          stall_q      <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pred_taken       = pred_q;
  assign aux_last_pred    = aux_pred_q;
  assign aux_pred_type    = aux_type_q;
  assign stall            = stall_q;
  assign mispredict_flush = flush_q;
  assign timeout_err      = tout_q;

`ifdef BPRED_STATS_EN
  logic [15:0] hits_q, miss_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q <= '0;
      miss_q <= '0;
    end else if (state_q == S_WAIT && checked) begin
      if (incorrect_pred) begin
        if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
      end else begin
        if (hits_q != 16'hFFFF) hits_q <= hits_q + 16'd1;
      end
    end
  end
  assign stat_hits   = hits_q;
  assign stat_misses = miss_q;
`endif

endmodule

// File: tb/tb_jne_predictor.sv
// Directed, table-driven bench for jne_predictor: training, saturation, stall, timeout, reset.
module tb_jne_predictor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_req;
  logic [1:0]  br_type;
  logic [11:0] pc;
  logic        checked, incorrect_pred, correct_pred;
  logic        pred_taken, aux_last_pred, stall, mispredict_flush, timeout_err;
  logic [1:0]  aux_pred_type;
`ifdef BPRED_STATS_EN
  logic [15:0] stat_hits, stat_misses;
`endif

  int total = 0;
  int bad   = 0;

  jne_predictor #(.IDX_BITS(4), .PC_W(12), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .br_req(br_req), .br_type(br_type), .pc(pc),
    .checked(checked), .incorrect_pred(incorrect_pred), .correct_pred(correct_pred),
    .pred_taken(pred_taken), .aux_last_pred(aux_last_pred), .aux_pred_type(aux_pred_type),
    .stall(stall), .mispredict_flush(mispredict_flush), .timeout_err(timeout_err)
`ifdef BPRED_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  // expected output vector: {pred, aux_pred, aux_type[1:0], stall, flush, timeout}
  typedef struct {
    logic        req;
    logic [1:0]  typ;
    logic [11:0] pc;
    logic        chk, inc, cor;
    logic [6:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic req, input logic [1:0] typ, input logic [11:0] a,
                             input logic chk, input logic inc, input logic cor,
                             input logic [6:0] exp);
    vec_t r;
    r.req = req; r.typ = typ; r.pc = a; r.chk = chk; r.inc = inc; r.cor = cor; r.exp = exp;
    return r;
  endfunction

  function automatic logic [6:0] outs();
    return {pred_taken, aux_last_pred, aux_pred_type, stall, mispredict_flush, timeout_err};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [1:0] typ, input logic [11:0] a,
                       input logic chk, input logic inc, input logic cor);
    br_req = req; br_type = typ; pc = a; checked = chk; incorrect_pred = inc; correct_pred = cor;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 2'b00, 12'h000, 0, 0, 0);
    #12;
    check("reset outputs", 16'(outs()), 16'h0);
`ifdef BPRED_STATS_EN
    check("reset stats", stat_hits | stat_misses, 16'h0);
`endif
    rst_n = 1'b1;

    // case 1: first JNE at 5 predicts not-taken, mispredicts -> ctr 10
    vecs.push_back(v(1, 2'b10, 12'h005, 0, 0, 0, 7'b0010100));
    vecs.push_back(v(0, 2'b00, 12'h000, 1, 1, 1, 7'b0010110));
    vecs.push_back(v(0, 2'b00, 12'h000, 0, 0, 0, 7'b0010000));
    // case 2: three taken JNEs at 5, 10->11->11
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(v(1, 2'b10, 12'h005, 0, 0, 0, 7'b1110100));
      vecs.push_back(v(0, 2'b00, 12'h000, 1, 0, 1, 7'b0110100));
      vecs.push_back(v(0, 2'b00, 12'h000, 0, 0, 0, 7'b0110000));
    end
    // saturated 11, one not-taken -> 10 still predicts taken
    vecs.push_back(v(1, 2'b10, 12'h005, 0, 0, 0, 7'b1110100));
    vecs.push_back(v(0, 2'b00, 12'h000, 1, 1, 0, 7'b0110110));
    vecs.push_back(v(0, 2'b00, 12'h000, 0, 0, 0, 7'b0110000));
    vecs.push_back(v(1, 2'b10, 12'h005, 0, 0, 0, 7'b1110100));
    vecs.push_back(v(0, 2'b00, 12'h000, 1, 0, 1, 7'b0110100));
    vecs.push_back(v(0, 2'b00, 12'h000, 0, 0, 0, 7'b0110000));
    // case 5: unconditional branches; checked in IDLE ignored
    vecs.push_back(v(1, 2'b01, 12'h003, 0, 0, 0, 7'b1110000));
    vecs.push_back(v(0, 2'b00, 12'h000, 1, 1, 1, 7'b0110000));
    vecs.push_back(v(1, 2'b11, 12'h003, 0, 0, 0, 7'b1110000));
    vecs.push_back(v(0, 2'b00, 12'h000, 0, 0, 0, 7'b0110000));
    // case 3: JNE at 7, br_req held through WAIT/UPDATE, accepted in next IDLE
    vecs.push_back(v(1, 2'b10, 12'h007, 0, 0, 0, 7'b0010100));
    for (int k = 0; k < 3; k++)
      vecs.push_back(v(1, 2'b10, 12'h005, 0, 0, 0, 7'b0010100));
    vecs.push_back(v(1, 2'b10, 12'h005, 1, 0, 0, 7'b0010100));
    vecs.push_back(v(1, 2'b10, 12'h005, 0, 0, 0, 7'b0010000));
    vecs.push_back(v(1, 2'b10, 12'h005, 0, 0, 0, 7'b1110100));
    vecs.push_back(v(0, 2'b00, 12'h000, 1, 0, 1, 7'b0110100));
    vecs.push_back(v(0, 2'b00, 12'h000, 0, 0, 0, 7'b0110000));
    // index 7 trained down to 00 still predicts not-taken
    vecs.push_back(v(1, 2'b10, 12'h007, 0, 0, 0, 7'b0010100));
    vecs.push_back(v(0, 2'b00, 12'h000, 1, 0, 0, 7'b0010100));
    vecs.push_back(v(0, 2'b00, 12'h000, 0, 0, 0, 7'b0010000));

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].typ, vecs[i].pc, vecs[i].chk, vecs[i].inc, vecs[i].cor);
      tick();
      check($sformatf("row %0d", i), 16'(outs()), 16'(vecs[i].exp));
`ifdef BPRED_STATS_EN
      if (i == 11) begin
        check("stat_hits", stat_hits, 16'd3);
        check("stat_misses", stat_misses, 16'd1);
      end
`endif
    end

    // case 4: timeout at pc 9, no table write
    drive(1, 2'b10, 12'h009, 0, 0, 0);
    tick();
    check("to enter", 16'(outs()), 16'(7'b0010100));
    drive(0, 2'b00, 12'h000, 0, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k < 15) check($sformatf("to wait %0d", k), 16'(outs()), 16'(7'b0010100));
      else        check("to pulse", 16'(outs()), 16'(7'b0010001));
    end
    tick();
    check("to clear", 16'(outs()), 16'(7'b0010000));
    // entry 9 still 01: taken training moves it to 10 -> predicts taken
    drive(1, 2'b10, 12'h009, 0, 0, 0); tick();
    check("to pred0", 16'(outs()), 16'(7'b0010100));
    drive(0, 2'b00, 12'h000, 1, 1, 1); tick();
    drive(0, 2'b00, 12'h000, 0, 0, 0); tick();
    drive(1, 2'b10, 12'h009, 0, 0, 0); tick();
    check("to pred1", 16'(outs()), 16'(7'b1110100));
    drive(0, 2'b00, 12'h000, 1, 0, 1); tick();
    drive(0, 2'b00, 12'h000, 0, 0, 0); tick();

    // checked on the 15th WAIT cycle beats the timeout
    drive(1, 2'b10, 12'h00C, 0, 0, 0); tick();
    drive(0, 2'b00, 12'h000, 0, 0, 0);
    for (int k = 1; k < 15; k++) tick();
    drive(0, 2'b00, 12'h000, 1, 1, 1); tick();
    check("chk beats to", 16'(outs()), 16'(7'b0010110));
    drive(0, 2'b00, 12'h000, 0, 0, 0); tick();
    check("chk beats to idle", 16'(outs()), 16'(7'b0010000));

    // case 6: reset mid-WAIT abandons the prediction
    drive(1, 2'b10, 12'h00B, 0, 0, 0); tick();
    drive(0, 2'b00, 12'h000, 0, 0, 0); tick();
    rst_n = 1'b0;
    #2;
    check("mid reset", 16'(outs()), 16'h0);
    rst_n = 1'b1;
    drive(0, 2'b00, 12'h000, 1, 1, 1); tick();
    check("post reset chk", 16'(outs()), 16'h0);
    drive(1, 2'b10, 12'h00B, 0, 0, 0); tick();
    check("post reset pred", 16'(outs()), 16'(7'b0010100));
    drive(1, 2'b10, 12'h005, 0, 0, 0); tick();
    check("post reset t5", 16'(outs()), 16'(7'b0010100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
